// File: rtl/fp_int_to_float.sv
// Multi-cycle 32-bit integer to IEEE-754 single-precision converter.
// Normalises by shifting one bit per cycle, then rounds to nearest, ties to even.
module fp_int_to_float #(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_inexact
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic        sign;
    logic [31:0] mag;
    logic [7:0]  exponent;

    logic        neg_in;
    logic [31:0] abs_in;
    logic        accept;
    logic [22:0] mant;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] mant_sum;
    logic [7:0]  exp_rnd;

    // Two's-complement negation of 0x80000000 wraps back to itself, which is the correct magnitude.
    assign neg_in   = SIGNED_IN && in_data[31];
    assign abs_in   = neg_in ? (~in_data + 32'd1) : in_data;
    assign in_ready = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept   = in_valid && in_ready;

    assign mant     = mag[30:8];
    assign guard    = mag[7];
    assign sticky   = |mag[6:0];
    assign round_up = guard & (sticky | mant[0]);
    assign mant_sum = {1'b0, mant} + {23'd0, round_up};
    assign exp_rnd  = exponent + {7'd0, mant_sum[23]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (abs_in == 32'd0) ? DONE : NORM;
            NORM:    if (mag[31]) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Results are only written when entering DONE, so they hold steady under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign        <= 1'b0;
            mag         <= 32'd0;
            exponent    <= 8'd0;
            out_result  <= 32'd0;
            out_inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign     <= neg_in;
                        mag      <= abs_in;
                        exponent <= 8'd158;
                        if (abs_in == 32'd0) begin
                            out_result  <= 32'd0;
                            out_inexact <= 1'b0;
                        end
                    end
                end
                NORM: begin
                    if (!mag[31]) begin
                        mag      <= mag << 1;
                        exponent <= exponent - 8'd1;
                    end
                end
                ROUND: begin
                    exponent    <= exp_rnd;
                    out_result  <= {sign, exp_rnd, mant_sum[22:0]};
                    out_inexact <= guard | sticky;
                end
                default: ;
            endcase
        end
    end

endmodule
